// File: rtl/seq_div_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding (common with
// seq_mult), default operand widths and a constant-width helper.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIVIDEND_LENGTH_DEF = 5;
  localparam int unsigned DIVISOR_LENGTH_DEF  = 2;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 1) ? value - 1 : 1;
    while (v != 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_div_if.sv
// Operand/result bundle for seq_div: ab_valid/ab_ready operand handshake and
// z_valid result strobe, same shape as the seq_mult bus.
interface seq_div_if #(
  parameter int unsigned Dividend_length = seq_div_pkg::DIVIDEND_LENGTH_DEF,
  parameter int unsigned Divisor_length  = seq_div_pkg::DIVISOR_LENGTH_DEF
);

  logic [Dividend_length-1:0] a;
  logic [Divisor_length-1:0]  b;
  logic                       ab_valid;
  logic                       ab_ready;
  logic [Dividend_length-1:0] q;
  logic [Divisor_length-1:0]  r;
  logic                       z_valid;
  logic                       div_by_zero;

  modport master (
    output a, b, ab_valid,
    input  ab_ready, q, r, z_valid, div_by_zero
  );

  modport slave (
    input  a, b, ab_valid,
    output ab_ready, q, r, z_valid, div_by_zero
  );

endinterface

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and either keep the difference or restore.
module div_step #(
  parameter int unsigned Divisor_length = 2
) (
  input  logic [Divisor_length-1:0] rem_in,
  input  logic                      bit_in,
  input  logic [Divisor_length-1:0] divisor,
  output logic [Divisor_length-1:0] rem_out,
  output logic                      q_bit
);

  logic [Divisor_length:0] shifted;
  logic [Divisor_length:0] diff;

  // The kept remainder is always below the divisor, so only the shifted
  // value and the trial difference need the extra sign bit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[Divisor_length];
    rem_out = q_bit ? diff[Divisor_length-1:0] : shifted[Divisor_length-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, quotient and
// remainder presented with a one-cycle z_valid strobe.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned Dividend_length = DIVIDEND_LENGTH_DEF,
  parameter int unsigned Divisor_length  = DIVISOR_LENGTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  seq_div_if.slave   bus
);

  localparam int unsigned DL = Dividend_length;
  localparam int unsigned DW = Divisor_length;
  localparam int unsigned CW = clog2(DL + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state;
  logic [DL-1:0]   dvd;
  logic [DW-1:0]   dvs;
  logic [DW-1:0]   rem;
  logic [CW-1:0]   cnt;
  logic [DL-1:0]   q_reg;
  logic [DW-1:0]   r_reg;
  logic            dbz_reg;

  logic            accept;
  logic [DW-1:0]   rem_next;
  logic            q_bit;
  logic [DL-1:0]   quo_next;

  div_step #(
    .Divisor_length(DW)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[DL-1]),
    .divisor (dvs),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after the last step the dividend register holds the quotient.
  assign quo_next = {dvd[DL-2:0], q_bit};

  assign bus.ab_ready    = (state == IDLE) || (state == DONE);
  assign accept          = bus.ab_valid && bus.ab_ready;
  assign bus.z_valid     = (state == DONE);
  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            dvd   <= bus.a;
            dvs   <= bus.b;
            rem   <= '0;
            cnt   <= CNT_LOAD;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          dvd <= quo_next;
          rem <= rem_next;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
            if (dvs == '0) begin
              q_reg   <= '1;
              r_reg   <= '0;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= quo_next;
              r_reg   <= rem_next;
              dbz_reg <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Randomized self-checking bench for seq_div at default widths (5/2),
// compared against plain integer division.
module tb_seq_div;

  localparam int unsigned DL = 5;
  localparam int unsigned DW = 2;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  logic [DL-1:0] last_q;
  logic [DW-1:0] last_r;
  logic          last_dbz;

  seq_div_if #(.Dividend_length(DL), .Divisor_length(DW)) ifc ();

  seq_div #(
    .Dividend_length(DL),
    .Divisor_length(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_q"},   32'(ifc.q),           32'(last_q));
    check({tag, "_r"},   32'(ifc.r),           32'(last_r));
    check({tag, "_dbz"}, 32'(ifc.div_by_zero), 32'(last_dbz));
  endtask

  // One idle clock with ab_valid low: no strobe, ready, results held.
  task automatic idle_cycle();
    ifc.ab_valid = 1'b0;
    ifc.a = DL'($urandom);
    ifc.b = DW'($urandom);
    @(posedge clk); #1;
    check("idle_zv", 32'(ifc.z_valid), 32'd0);
    check("idle_ready", 32'(ifc.ab_ready), 32'd1);
    check_hold("idle");
  endtask

  // Offer one operation; the block must be ready now. Ends in the DONE
  // cycle with ab_valid low, so a following run_op chains back-to-back.
  task automatic run_op(input int unsigned av, input int unsigned bv);
    logic [DL-1:0] eq;
    logic [DW-1:0] er;
    logic          ed;
    if (bv == 0) begin
      eq = '1;
      er = '0;
      ed = 1'b1;
    end else begin
      eq = DL'(av / bv);
      er = DW'(av % bv);
      ed = 1'b0;
    end
    ifc.a = DL'(av);
    ifc.b = DW'(bv);
    ifc.ab_valid = 1'b1;
    check("accept_ready", 32'(ifc.ab_ready), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < int'(DL); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check("busy_ready", 32'(ifc.ab_ready), 32'd0);
      check("busy_zv", 32'(ifc.z_valid), 32'd0);
      check_hold("busy");
      ifc.ab_valid = 1'($urandom);
      ifc.a = DL'($urandom);
      ifc.b = DW'($urandom);
    end
    @(posedge clk); #1;
    check("done_zv", 32'(ifc.z_valid), 32'd1);
    check("done_ready", 32'(ifc.ab_ready), 32'd1);
    check("done_q", 32'(ifc.q), 32'(eq));
    check("done_r", 32'(ifc.r), 32'(er));
    check("done_dbz", 32'(ifc.div_by_zero), 32'(ed));
    last_q = eq;
    last_r = er;
    last_dbz = ed;
    ifc.ab_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_q = '0;
    last_r = '0;
    last_dbz = 1'b0;

    // Reset state, with operands offered that must be ignored.
    rst = 1'b0;
    ifc.ab_valid = 1'b1;
    ifc.a = DL'(23);
    ifc.b = DW'(3);
    #1;
    check("rst_zv", 32'(ifc.z_valid), 32'd0);
    check("rst_ready", 32'(ifc.ab_ready), 32'd1);
    check_hold("rst");
    repeat (2) @(posedge clk);
    #1;
    check("rst_ignore_ready", 32'(ifc.ab_ready), 32'd1);
    check("rst_ignore_zv", 32'(ifc.z_valid), 32'd0);
    @(negedge clk);
    ifc.ab_valid = 1'b0;
    rst = 1'b1;
    idle_cycle();
    idle_cycle();

    // Directed cases.
    run_op(23, 3);
    idle_cycle();
    run_op(31, 1);
    idle_cycle();
    run_op(2, 3);
    idle_cycle();
    run_op(5, 0);
    run_op(20, 3);
    run_op(9, 2);
    idle_cycle();
    idle_cycle();

    // Random operations, randomly chained or separated by idle cycles.
    for (int n = 0; n < 40; n++) begin
      run_op($urandom_range(0, 31), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    run_op(0, 0);
    run_op(31, 3);
    idle_cycle();

    // Reset during step 3 of 23/3.
    ifc.a = DL'(23);
    ifc.b = DW'(3);
    ifc.ab_valid = 1'b1;
    @(posedge clk); #1;
    ifc.ab_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    last_q = '0;
    last_r = '0;
    last_dbz = 1'b0;
    check("midrst_zv", 32'(ifc.z_valid), 32'd0);
    check("midrst_ready", 32'(ifc.ab_ready), 32'd1);
    check_hold("midrst");
    ifc.ab_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_held_ready", 32'(ifc.ab_ready), 32'd1);
    @(negedge clk);
    ifc.ab_valid = 1'b0;
    rst = 1'b1;
    run_op(7, 2);
    idle_cycle();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider. It is the inverse companion of the sequential multiplier `seq_mult` and uses the same `ab_valid`/`ab_ready` input handshake and `z_valid` result strobe. The block accepts an unsigned dividend and divisor, produces one quotient bit per clock, and presents quotient and remainder with a one-cycle valid pulse. It sits beside `seq_mult` in the arithmetic datapath and is driven by the same kind of random-stimulus bench.

## Interface
- `Dividend_length`, default 5: width of dividend `a` and quotient `q`; also the number of iteration cycles.
- `Divisor_length`, default 2: width of divisor `b` and remainder `r`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `a` in `Dividend_length`: dividend, unsigned.
- `b` in `Divisor_length`: divisor, unsigned.
- `ab_valid` in 1: the operands on `a`/`b` are valid this cycle.
- `ab_ready` out 1: the block can accept operands this cycle.
- `q` out `Dividend_length`: quotient, valid while `z_valid`=1.
- `r` out `Divisor_length`: remainder, valid while `z_valid`=1.
- `z_valid` out 1: one-cycle strobe marking `q`/`r`/`div_by_zero` as valid.
- `div_by_zero` out 1: the result belongs to an operation with `b`=0.

## Operation
- **States:**
  - IDLE (reset state).
  - BUSY: iterations in progress.
  - DONE: result presented.
- **Outputs:**
  - `ab_ready` = (state is IDLE or DONE), driven combinationally from state.
  - `z_valid` = (state is DONE).
- **Accept:** an operation is accepted on a rising edge where `ab_valid` & `ab_ready` = 1. On accept:
  - latch `a` and `b`;
  - clear the partial remainder (`Divisor_length`+1 bits wide);
  - load the iteration count with `Dividend_length`;
  - go to BUSY.
- **BUSY step, one per edge:**
  - shift the next dividend bit (MSB first) into the partial remainder;
  - trial-subtract the divisor;
  - if the result is non-negative, keep the difference and record quotient bit 1;
  - otherwise restore the partial remainder and record quotient bit 0;
  - decrement the count.
  - On the edge that completes the last step, register `q` and `r` and go to DONE.
- **DONE:**
  - on an accept edge, go to BUSY; this gives back-to-back operations;
  - otherwise go to IDLE.
- **Input gating:**
  - `a`, `b` and `ab_valid` are ignored in BUSY; X on them there must not propagate.
  - In IDLE with `ab_valid`=0, there is no state change.
- **Divide by zero (latched `b`=0):**
  - run the full iteration count, keeping the latency fixed;
  - force `q` to all ones and `r` to 0;
  - `div_by_zero`=1 with the result.
  - For all other results `div_by_zero`=0.
- **Holding:** `q`, `r` and `div_by_zero` hold their last values after DONE, until the next result overwrites them.
- **No backpressure:** the result is not stalled. A consumer must sample it during the `z_valid` cycle.
- **Arithmetic:** unsigned only. The trial subtract is `Divisor_length`+1 bits wide, and its sign bit selects the quotient bit.

## Timing
- **Reset:** while `rst`=0, asynchronously:
  - state = IDLE;
  - `q`=0, `r`=0, `div_by_zero`=0, `z_valid`=0;
  - count and operand registers cleared;
  - `ab_ready`=1, but inputs are ignored until `rst` returns high.
- **Latency:**
  - accept at edge 0;
  - iteration steps at edges 1 through `Dividend_length`;
  - `z_valid` high for exactly the cycle after edge `Dividend_length`.
- **Throughput:** one operation every `Dividend_length`+1 cycles, achieved by accepting during the DONE cycle.
- **Reset mid-operation:** the operation in progress is discarded, and no `z_valid` is produced for it. The first accept is possible on the first edge after `rst` rises.
- **Simultaneous events:** in the DONE cycle, `z_valid`=1 and a new accept can happen in the same cycle. The registered result remains valid for that cycle.

## Structure
- A shared include file `seq_arith_defs.vh` holds:
  - the state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), also reused by `seq_mult`;
  - a `clog2` helper function for the counter width (`clog2(Dividend_length+1)`).
- One sub-module, `div_step`, is combinational:
  - inputs: partial remainder, incoming dividend bit, divisor;
  - outputs: next partial remainder and quotient bit;
  - the top level instantiates it once.

## Test plan
Use default parameters (5/2) for all scenarios.
- **Basic division:** `a`=23, `b`=3 accepted → `z_valid` exactly 5 cycles later; `q`=7, `r`=2, `div_by_zero`=0.
- **Divisor of one, dividend smaller than divisor:**
  - `a`=31, `b`=1 → `q`=31, `r`=0.
  - `a`=2, `b`=3 → `q`=0, `r`=2.
- **Divide by zero:** `a`=5, `b`=0 → after 5 cycles, `q`=31, `r`=0, `div_by_zero`=1. The next normal operation clears `div_by_zero`.
- **Back-to-back:** hold `ab_valid`=1 with 20/3, then 9/2. Required response:
  - first result `q`=6, `r`=2;
  - second accepted in the same DONE cycle;
  - second `z_valid` 5 cycles later, with `q`=4, `r`=1.
- **Random inputs during BUSY:** drive `ab_valid`, `a` and `b` randomly while BUSY → ignored; `ab_ready`=0 throughout BUSY, and the result matches the latched operands.
- **Reset mid-operation:** pull `rst` low during step 3 of 23/3. Required response:
  - all outputs 0 immediately, with no `z_valid`;
  - after release, 7/2 yields `q`=3, `r`=1.
